// File: rtl/prog_ram_loader_if.sv
// Bus between the accumulator CPU / load pins and the writable program store.
// master: drives the load pins and the fetch address. slave: the program store.
interface prog_ram_loader_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          load_en;
  logic          wr_strobe;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr;
  logic          ready;
  logic [AW:0]   wr_count;
  logic [DW-1:0] csum;

  modport master (
    output load_en, wr_strobe, wr_data, pc,
    input  instr, ready, wr_count, csum
  );

  modport slave (
    input  load_en, wr_strobe, wr_data, pc,
    output instr, ready, wr_count, csum
  );
endinterface

// File: rtl/prog_ram_loader.sv
// Writable program store for the accumulator CPU. Bytes arrive serially from
// pins (wr_strobe rising edges while load_en is high); once PROG_LEN bytes are
// resident, ready rises and instr serves mem[pc] combinationally.
// Optional feature: define LOADER_CHECKSUM_EN to keep a running XOR of the
// bytes written since the last load start on csum (otherwise csum is 0).
module prog_ram_loader #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int PROG_LEN = 6
) (
  input logic              clk,
  input logic              rst_n,
  prog_ram_loader_if.slave bus
);

  localparam int          DEPTH      = 2 ** AW;
  localparam logic [AW:0] PROG_LEN_W = (AW + 1)'(PROG_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   wr_count_q, wr_count_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Three-flop chains: meta, synchronised level, previous level for edges.
  logic load_meta_q, load_s_q, load_prev_q;
  logic strb_meta_q, strb_s_q, strb_prev_q;

  logic ld_rise, strb_rise;
  logic load_start;  // entering LOAD: counters clear
  logic wr_en;       // a byte is written this cycle

  assign ld_rise   = load_s_q & ~load_prev_q;
  assign strb_rise = strb_s_q & ~strb_prev_q;

  // Pin synchronisers and edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_meta_q <= 1'b0;
      load_s_q    <= 1'b0;
      load_prev_q <= 1'b0;
      strb_meta_q <= 1'b0;
      strb_s_q    <= 1'b0;
      strb_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its input
      // before any of them updates, so the chain shifts one stage per clock.
      load_meta_q <= bus.load_en;
      load_s_q    <= load_meta_q;
      load_prev_q <= load_s_q;
      strb_meta_q <= bus.wr_strobe;
      strb_s_q    <= strb_meta_q;
      strb_prev_q <= strb_s_q;
    end
  end

  // Next state, write enable and write address for the load sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    wr_count_d = wr_count_q;
    mem_d      = mem_q;
    load_start = 1'b0;
    wr_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ld_rise) begin
          state_d    = LOAD;
          wr_count_d = '0;
          load_start = 1'b1;
        end
      end

      LOAD: begin
        // The write happens first; completion takes priority over abort.
        if (strb_rise) begin
          wr_en                          = 1'b1;
          mem_d[wr_count_q[AW-1:0]]      = bus.wr_data;
          wr_count_d                     = wr_count_q + (AW + 1)'(1);
        end
        if (strb_rise && (wr_count_d == PROG_LEN_W)) begin
          state_d = READY;
        end else if (!load_s_q) begin
          state_d = IDLE;
        end
      end

      READY: begin
        // Strobes are ignored here; only a fresh load_en rise reloads.
        if (ld_rise) begin
          state_d    = LOAD;
          wr_count_d = '0;
          load_start = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counter and program memory registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_count_q <= '0;
      // NOTE: the store is cleared on reset so a CPU never fetches stale
      // code; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;

  // Running XOR of bytes written since the last load start.
  always_comb begin
    csum_d = csum_q;
    if (load_start)  csum_d = '0;
    else if (wr_en)  csum_d = csum_q ^ bus.wr_data;
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign bus.csum = csum_q;
`else
  assign bus.csum = '0;
`endif

  assign bus.ready    = (state_q == READY);
  assign bus.wr_count = wr_count_q;
  // Zero-latency fetch; outside the program or before it is complete, a NOP of 0.
  assign bus.instr    = ((state_q == READY) && ({1'b0, bus.pc} < PROG_LEN_W))
                        ? mem_q[bus.pc] : '0;

endmodule

// File: tb/tb_prog_ram_loader.sv
// Self-checking bench for prog_ram_loader: directed scenarios plus random
// programs, compared against a transaction-level model of the program store.
module tb_prog_ram_loader;

  localparam int AW       = 4;
  localparam int DW       = 8;
  localparam int PROG_LEN = 6;
  localparam int DEPTH    = 2 ** AW;

  logic clk = 1'b0;
  logic rst_n;

  prog_ram_loader_if #(.AW(AW), .DW(DW)) bus ();

  prog_ram_loader #(.AW(AW), .DW(DW), .PROG_LEN(PROG_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: program contents and load progress per transaction.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_loading;
  bit            ref_ready;
  int            ref_count;
  logic [DW-1:0] ref_csum;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_loading = 0;
    ref_ready   = 0;
    ref_count   = 0;
    ref_csum    = '0;
  endfunction

  function automatic void model_begin_load();
    ref_loading = 1;
    ref_ready   = 0;
    ref_count   = 0;
    ref_csum    = '0;
  endfunction

  function automatic void model_write(input logic [DW-1:0] b);
    if (ref_loading && ref_count < PROG_LEN) begin
      ref_mem[ref_count] = b;
      ref_count++;
      ref_csum ^= b;
      if (ref_count == PROG_LEN) begin
        ref_loading = 0;
        ref_ready   = 1;
      end
    end
  endfunction

  function automatic void model_release_load();
    if (ref_loading) ref_loading = 0;  // abort keeps written bytes
  endfunction

  // Compare every observable output against the model.
  task automatic check_all(input string tag);
    logic [DW-1:0] exp_csum;
    logic [DW-1:0] exp_instr;
`ifdef LOADER_CHECKSUM_EN
    exp_csum = ref_csum;
`else
    exp_csum = '0;
`endif
    check({tag, ".ready"},    32'(bus.ready),    32'(ref_ready));
    check({tag, ".wr_count"}, 32'(bus.wr_count), 32'(ref_count));
    check({tag, ".csum"},     32'(bus.csum),     32'(exp_csum));
    for (int p = 0; p < DEPTH; p++) begin
      bus.pc = AW'(p);
      #1;
      exp_instr = (ref_ready && p < PROG_LEN) ? ref_mem[p] : '0;
      check($sformatf("%s.instr[%0d]", tag, p), 32'(bus.instr), 32'(exp_instr));
    end
  endtask

  task automatic strobe_byte(input logic [DW-1:0] b);
    @(negedge clk);
    bus.wr_data   = b;
    bus.wr_strobe = 1'b1;
    repeat (4) @(negedge clk);
    bus.wr_strobe = 1'b0;
    repeat (4) @(negedge clk);
    model_write(b);
  endtask

  task automatic release_load();
    @(negedge clk);
    bus.load_en = 1'b0;
    repeat (4) @(negedge clk);
    model_release_load();
  endtask

  task automatic start_load();
    release_load();
    bus.load_en = 1'b1;
    repeat (4) @(negedge clk);
    model_begin_load();
  endtask

  initial begin
    int n;
    logic [DW-1:0] b;

    rst_n         = 1'b0;
    bus.load_en   = 1'b0;
    bus.wr_strobe = 1'b0;
    bus.wr_data   = '0;
    bus.pc        = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full directed load; first byte also measures strobe-to-write latency
    // and confirms a long strobe writes only once.
    start_load();
    bus.wr_data   = 8'h15;
    bus.wr_strobe = 1'b1;
    repeat (2) @(negedge clk);
    check("latency.before", 32'(bus.wr_count), 32'd0);
    @(negedge clk);
    check("latency.landed", 32'(bus.wr_count), 32'd1);
    repeat (7) @(negedge clk);
    check("long_strobe.once", 32'(bus.wr_count), 32'd1);
    bus.wr_strobe = 1'b0;
    repeat (4) @(negedge clk);
    model_write(8'h15);
    strobe_byte(8'h25);
    strobe_byte(8'h35);
    strobe_byte(8'h45);
    strobe_byte(8'h55);
    strobe_byte(8'h65);
    check_all("full");

    // Overflow strobes while READY with load_en still high.
    repeat (3) strobe_byte(8'hFF);
    check_all("overflow");

    // Reload: ready falls three clocks after the load_en rise.
    release_load();
    bus.load_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reload.ready_hold", 32'(bus.ready), 32'd1);
    @(negedge clk);
    check("reload.ready_drop", 32'(bus.ready), 32'd0);
    repeat (2) @(negedge clk);
    model_begin_load();
    for (int i = 0; i < PROG_LEN; i++) strobe_byte(8'($urandom));
    check_all("reload");

    // Abort after two bytes, then a full load.
    start_load();
    strobe_byte(8'hAA);
    strobe_byte(8'hBB);
    release_load();
    check_all("abort");
    start_load();
    for (int i = 0; i < PROG_LEN; i++) strobe_byte(8'($urandom));
    check_all("after_abort");

    // Random programs of random length, sometimes aborted, sometimes overrun.
    for (int t = 0; t < 6; t++) begin
      start_load();
      n = $urandom_range(1, PROG_LEN + 2);
      for (int i = 0; i < n; i++) strobe_byte(8'($urandom));
      if ($urandom_range(0, 1) == 1) release_load();
      check_all($sformatf("rand%0d", t));
    end

    // Asynchronous reset in the middle of a load.
    start_load();
    strobe_byte(8'h5A);
    strobe_byte(8'hC3);
    @(posedge clk);
    #2;
    rst_n         = 1'b0;
    bus.load_en   = 1'b0;
    bus.wr_strobe = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_load();
    for (int i = 0; i < PROG_LEN; i++) strobe_byte(8'($urandom));
    check_all("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
